// File: rtl/stream_filter_pkg.sv
// Shared definitions for the stream filter: controller state encoding and phase lengths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t       - delay controller FSM state encoding
//   CFG_CYCLES    - cycles the delay_mem configuration strobe is held
//   SETTLE_CYCLES - cycles allowed for delay_mem to take the config and clear pointers
//   phase_load()  - preload value for the down-counting phase timer
package stream_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int CFG_CYCLES    = 1;
    localparam int SETTLE_CYCLES = 2;

    // Wide enough for the longest timed phase.
    localparam int PHASE_W = 2;

    // Phase timers count down to zero, so a phase of N cycles is loaded with N-1.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/frame_cnt.sv
// Column/row position counter for a raster-scanned frame.
// Latency: position updates on the clock edge after an enabled cycle; end flags are combinational.
// Backpressure: none internally; en low holds both counters for any number of cycles.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   clr                 - synchronous clear of both counters (frame start)
//   en                  - advance one pixel
//   width, height       - wrap limits (row length, row count)
//   col, row            - current pixel position
//   col_last, row_last  - current pixel is in the last column / last row
module frame_cnt #(
    parameter int CW = 12,
    parameter int RW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] width,
    input  logic [RW-1:0] height,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_last,
    output logic          row_last
);

    localparam logic [CW:0]   C_ONE_X = {{CW{1'b0}}, 1'b1};
    localparam logic [RW:0]   R_ONE_X = {{RW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] R_ONE   = {{(RW-1){1'b0}}, 1'b1};

    // Compare position+1 against the limit one bit wider, so the largest legal
    // width cannot wrap the compare and a zero limit never matches spuriously.
    assign col_last = (({1'b0, col} + C_ONE_X) == {1'b0, width});
    assign row_last = (({1'b0, row} + R_ONE_X) == {1'b0, height});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : (row + R_ONE);
            end else begin
                col <= col + C_ONE;
            end
        end
    end

endmodule

// File: rtl/delay_ctrl.sv
// Frame controller for a KERNELxKERNEL line-buffer window built from delay_mem instances.
// Latency: win_* flags are registered one cycle after the accepting cycle (aligned with delay_mem dn_data).
// Backpressure: up_rdy is low outside RUN (config, settle, done); gaps on up_val are legal and hold all state.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   cfg_width, cfg_height    - frame geometry, sampled on an accepted cfg_start
//   cfg_start                - single-cycle frame start request
//   cfg_busy                 - controller is not idle
//   cfg_err                  - one-cycle pulse: start request rejected (bad geometry or not idle)
//   mem_cfg_delay/set        - delay value and strobe broadcast to every delay_mem
//   up_val, up_rdy, mem_val  - upstream handshake; mem_val = accepted pixel, drives delay_mem up_val
//   win_val/eol/eof          - window complete / last column / last pixel of frame
//   done                     - one-cycle pulse at frame completion
module delay_ctrl
    import stream_filter_pkg::*;
#(
    parameter int MEM_AWIDTH = 12,
    parameter int ROW_AWIDTH = 12,
    parameter int KERNEL     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_AWIDTH-1:0] cfg_width,
    input  logic [ROW_AWIDTH-1:0] cfg_height,
    input  logic                  cfg_start,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic [MEM_AWIDTH-1:0] mem_cfg_delay,
    output logic                  mem_cfg_set,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic                  mem_val,
    output logic                  win_val,
    output logic                  win_eol,
    output logic                  win_eof,
    output logic                  done
);

    // Geometry limits, one bit wider than the fields so no compare can wrap.
    localparam logic [MEM_AWIDTH:0] K_W    = (MEM_AWIDTH + 1)'(KERNEL);
    localparam logic [ROW_AWIDTH:0] K_H    = (ROW_AWIDTH + 1)'(KERNEL);
    localparam logic [MEM_AWIDTH:0] W_MAX  = {1'b0, {MEM_AWIDTH{1'b1}}};
    // Window is complete once KERNEL-1 earlier rows/columns exist.
    localparam logic [MEM_AWIDTH-1:0] K_COL = MEM_AWIDTH'(KERNEL - 1);
    localparam logic [ROW_AWIDTH-1:0] K_ROW = ROW_AWIDTH'(KERNEL - 1);
    localparam logic [PHASE_W-1:0]    PH_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [PHASE_W-1:0]     phase;
    logic [MEM_AWIDTH-1:0]  width_q;
    logic [ROW_AWIDTH-1:0]  height_q;

    logic [MEM_AWIDTH-1:0]  col;
    logic [ROW_AWIDTH-1:0]  row;
    logic                   col_last;
    logic                   row_last;
    logic                   frame_end;
    logic                   cnt_clr;
    logic                   cfg_bad;

    assign mem_val   = up_val & up_rdy;
    assign cfg_busy  = (state != ST_IDLE);
    assign frame_end = col_last & row_last;
    // Counters restart for every frame while the delay_mems are being configured.
    assign cnt_clr   = (state == ST_CFG);

    // The upper-bound test only bites if the field is ever made wider than delay_mem depth.
    assign cfg_bad = ({1'b0, cfg_width}  <  K_W)   ||
                     ({1'b0, cfg_height} <  K_H)   ||
                     ({1'b0, cfg_width}  >  W_MAX);

    frame_cnt #(
        .CW (MEM_AWIDTH),
        .RW (ROW_AWIDTH)
    ) u_frame_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (mem_val),
        .width    (width_q),
        .height   (height_q),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            phase         <= '0;
            width_q       <= '0;
            height_q      <= '0;
            mem_cfg_delay <= '0;
            mem_cfg_set   <= 1'b0;
            cfg_err       <= 1'b0;
            up_rdy        <= 1'b0;
            done          <= 1'b0;
        end else begin
            cfg_err     <= 1'b0;
            mem_cfg_set <= 1'b0;
            done        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state         <= ST_CFG;
                            phase         <= phase_load(CFG_CYCLES);
                            mem_cfg_set   <= 1'b1;
                            mem_cfg_delay <= cfg_width;
                        end
                    end
                end

                ST_CFG: begin
                    if (phase == '0) begin
                        state <= ST_SETTLE;
                        phase <= phase_load(SETTLE_CYCLES);
                    end else begin
                        phase       <= phase - PH_ONE;
                        mem_cfg_set <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (phase == '0) begin
                        state  <= ST_RUN;
                        up_rdy <= 1'b1;
                    end else begin
                        phase <= phase - PH_ONE;
                    end
                end

                ST_RUN: begin
                    if (mem_val && frame_end) begin
                        state  <= ST_DONE;
                        up_rdy <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    up_rdy <= 1'b0;
                end
            endcase

            // A start request while busy never disturbs the frame in flight.
            if (cfg_start && (state != ST_IDLE)) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Window flags describe the pixel accepted on the previous cycle, so they land
    // together with the delay_mem output update; a non-accepting cycle clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_val <= 1'b0;
            win_eol <= 1'b0;
            win_eof <= 1'b0;
        end else begin
            win_val <= mem_val && (col >= K_COL) && (row >= K_ROW);
            win_eol <= mem_val && col_last;
            win_eof <= mem_val && frame_end;
        end
    end

endmodule
